// File: rtl/program_result_monitor_pkg.sv
// Shared types for the end-of-program result monitor: verdict encoding, FSM states,
// the default runaway-program limit and a saturating counter helper.
package monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_PASS       = 3'd2,
        ST_FAIL_VALUE = 3'd3,
        ST_FAIL_ORDER = 3'd4,
        ST_FAIL_FETCH = 3'd5,
        ST_TIMEOUT    = 3'd6
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam int TIMEOUT_DEFAULT = 10000;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/program_result_monitor_match.sv
// Combinational slot matcher: finds the lowest-index enabled, not-yet-matched slot whose
// expected address equals the bus address, and reports whether the write data agrees.
module result_check_match #(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 4,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_CHECKS-1:0]      chk_en,
    input  logic [NUM_CHECKS-1:0]      matched,
    input  logic [NUM_CHECKS*XLEN-1:0] chk_addr,
    input  logic [NUM_CHECKS*XLEN-1:0] chk_value,
    input  logic [XLEN-1:0]            mem_adr,
    input  logic [XLEN-1:0]            mem_write_data,
    output logic                       hit,
    output logic [IDX_W-1:0]           hit_index,
    output logic                       data_eq
);

    // Scan high to low so the last assignment wins, leaving the lowest matching slot.
    always_comb begin
        hit       = 1'b0;
        hit_index = '0;
        data_eq   = 1'b0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (chk_en[i] && !matched[i] && (chk_addr[i*XLEN +: XLEN] == mem_adr)) begin
                hit       = 1'b1;
                hit_index = IDX_W'(i);
                data_eq   = (chk_value[i*XLEN +: XLEN] == mem_write_data);
            end
        end
    end

endmodule

// File: rtl/program_result_monitor.sv
// End-of-program checker: snoops data-memory writes against up to NUM_CHECKS expected
// (address, value) pairs and registers a sticky PASS / FAIL / TIMEOUT verdict.
module program_result_monitor
    import monitor_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int ORDERED        = 0,
    localparam int IDX_W         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_CHECKS-1:0]      chk_en,
    input  logic [NUM_CHECKS*XLEN-1:0] chk_addr,
    input  logic [NUM_CHECKS*XLEN-1:0] chk_value,
    input  logic                       mem_en,
    input  logic                       mem_write_en,
    input  logic [XLEN-1:0]            mem_adr,
    input  logic [XLEN-1:0]            mem_write_data,
    input  logic                       instr_valid,
    output logic                       done,
    output status_t                    status,
    output logic [IDX_W-1:0]           fail_index,
    output logic [XLEN-1:0]            fail_data,
    output logic [NUM_CHECKS-1:0]      matched,
    output logic [31:0]                cycle_count
);

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    state_t                     state_q, state_d;
    status_t                    status_q, status_d;
    logic                       done_q, done_d;
    logic [IDX_W-1:0]           fail_index_q, fail_index_d;
    logic [XLEN-1:0]            fail_data_q, fail_data_d;
    logic [NUM_CHECKS-1:0]      matched_q, matched_d;
    logic [31:0]                count_q, count_d;

    logic [NUM_CHECKS-1:0]      en_q;
    logic [NUM_CHECKS*XLEN-1:0] addr_q;
    logic [NUM_CHECKS*XLEN-1:0] value_q;

    logic                       hit;
    logic [IDX_W-1:0]           hit_index;
    logic                       data_eq;
    logic                       snoop;
    logic [IDX_W-1:0]           exp_index;
    logic                       order_ok;
    logic [NUM_CHECKS-1:0]      matched_upd;

    result_check_match #(
        .XLEN       (XLEN),
        .NUM_CHECKS (NUM_CHECKS),
        .IDX_W      (IDX_W)
    ) u_match (
        .chk_en         (en_q),
        .matched        (matched_q),
        .chk_addr       (addr_q),
        .chk_value      (value_q),
        .mem_adr        (mem_adr),
        .mem_write_data (mem_write_data),
        .hit            (hit),
        .hit_index      (hit_index),
        .data_eq        (data_eq)
    );

    assign snoop = mem_en & mem_write_en;

    // Next slot an in-order program must complete: lowest enabled slot still outstanding.
    always_comb begin
        exp_index = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (en_q[i] && !matched_q[i]) begin
                exp_index = IDX_W'(i);
            end
        end
    end

    assign order_ok = (ORDERED == 0) || (hit_index == exp_index);

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        done_d       = done_q;
        fail_index_d = fail_index_q;
        fail_data_d  = fail_data_q;
        matched_d    = matched_q;
        count_d      = count_q;
        matched_upd  = matched_q;

        if (start) begin
            state_d      = S_RUN;
            status_d     = ST_RUN;
            done_d       = 1'b0;
            fail_index_d = '0;
            fail_data_d  = '0;
            matched_d    = '0;
            count_d      = '0;
        end else if (state_q == S_RUN) begin
            count_d = sat_inc32(count_q);
            if (snoop && hit && order_ok && data_eq) begin
                matched_upd[hit_index] = 1'b1;
            end

            // Bus faults outrank completion, completion outranks fetch and timeout.
            if (snoop && hit && !order_ok) begin
                state_d      = S_FAIL;
                status_d     = ST_FAIL_ORDER;
                done_d       = 1'b1;
                fail_index_d = hit_index;
                fail_data_d  = mem_write_data;
            end else if (snoop && hit && !data_eq) begin
                state_d      = S_FAIL;
                status_d     = ST_FAIL_VALUE;
                done_d       = 1'b1;
                fail_index_d = hit_index;
                fail_data_d  = mem_write_data;
            end else if (matched_upd == en_q) begin
                state_d   = S_PASS;
                status_d  = ST_PASS;
                done_d    = 1'b1;
                matched_d = matched_upd;
            end else if (!instr_valid) begin
                state_d      = S_FAIL;
                status_d     = ST_FAIL_FETCH;
                done_d       = 1'b1;
                fail_index_d = '0;
                matched_d    = matched_upd;
            end else if (count_d == TIMEOUT_LIM) begin
                state_d   = S_TIMEOUT;
                status_d  = ST_TIMEOUT;
                done_d    = 1'b1;
                matched_d = matched_upd;
            end else begin
                matched_d = matched_upd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            status_q     <= ST_IDLE;
            done_q       <= 1'b0;
            fail_index_q <= '0;
            fail_data_q  <= '0;
            matched_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            done_q       <= done_d;
            fail_index_q <= fail_index_d;
            fail_data_q  <= fail_data_d;
            matched_q    <= matched_d;
            count_q      <= count_d;
        end
    end

    // Check configuration is only consulted in RUN, which is reachable only through start.
    always_ff @(posedge clk) begin
        if (start) begin
            en_q    <= chk_en;
            addr_q  <= chk_addr;
            value_q <= chk_value;
        end
    end

    assign done        = done_q;
    assign status      = status_q;
    assign fail_index  = fail_index_q;
    assign fail_data   = fail_data_q;
    assign matched     = matched_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_program_result_monitor.sv
// Directed bench: an unordered and an ordered monitor watch the same bus; expected verdicts
// are queued per instance and checked by independent monitors when done rises.
module tb_program_result_monitor;
    import monitor_pkg::*;

    localparam int XLEN = 32;
    localparam int NC   = 4;
    localparam int TO   = 50;

    typedef struct packed {
        status_t     st;
        logic [1:0]  fidx;
        logic [31:0] fdata;
        logic [3:0]  matched;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, start, mem_en, mem_write_en, instr_valid;
    logic [NC-1:0]        chk_en;
    logic [NC*XLEN-1:0]   chk_addr, chk_value;
    logic [XLEN-1:0]      mem_adr, mem_write_data;

    logic        done_a, done_b;
    status_t     status_a, status_b;
    logic [1:0]  fidx_a, fidx_b;
    logic [31:0] fdata_a, fdata_b;
    logic [3:0]  matched_a, matched_b;
    logic [31:0] cnt_a, cnt_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;

    program_result_monitor #(.XLEN(XLEN), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO), .ORDERED(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .chk_en(chk_en), .chk_addr(chk_addr),
        .chk_value(chk_value), .mem_en(mem_en), .mem_write_en(mem_write_en), .mem_adr(mem_adr),
        .mem_write_data(mem_write_data), .instr_valid(instr_valid), .done(done_a),
        .status(status_a), .fail_index(fidx_a), .fail_data(fdata_a), .matched(matched_a),
        .cycle_count(cnt_a)
    );

    program_result_monitor #(.XLEN(XLEN), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO), .ORDERED(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .chk_en(chk_en), .chk_addr(chk_addr),
        .chk_value(chk_value), .mem_en(mem_en), .mem_write_en(mem_write_en), .mem_adr(mem_adr),
        .mem_write_data(mem_write_data), .instr_valid(instr_valid), .done(done_b),
        .status(status_b), .fail_index(fidx_b), .fail_data(fdata_b), .matched(matched_b),
        .cycle_count(cnt_b)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_verdict(input string tag, input exp_t e, input status_t st,
                                 input logic [1:0] fi, input logic [31:0] fd,
                                 input logic [3:0] m, input logic [31:0] c);
        chk32({tag, ".status"},      32'(st), 32'(e.st));
        chk32({tag, ".fail_index"},  32'(fi), 32'(e.fidx));
        chk32({tag, ".fail_data"},   fd,      e.fdata);
        chk32({tag, ".matched"},     32'(m),  32'(e.matched));
        chk32({tag, ".cycle_count"}, c,       e.cnt);
    endtask

    task automatic check_now(input string tag, input logic d, input status_t st, input logic [3:0] m,
                             input logic [31:0] c);
        chk32({tag, ".A.done"},   32'(done_a),    32'(d));
        chk32({tag, ".A.status"}, 32'(status_a),  32'(st));
        chk32({tag, ".A.fidx"},   32'(fidx_a),    32'd0);
        chk32({tag, ".A.fdata"},  fdata_a,        32'd0);
        chk32({tag, ".A.match"},  32'(matched_a), 32'(m));
        chk32({tag, ".A.count"},  cnt_a,          c);
        chk32({tag, ".B.done"},   32'(done_b),    32'(d));
        chk32({tag, ".B.status"}, 32'(status_b),  32'(st));
        chk32({tag, ".B.fidx"},   32'(fidx_b),    32'd0);
        chk32({tag, ".B.fdata"},  fdata_b,        32'd0);
        chk32({tag, ".B.match"},  32'(matched_b), 32'(m));
        chk32({tag, ".B.count"},  cnt_b,          c);
    endtask

    initial begin : mon_a
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_a && !prev) begin
                if (q_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL A.unexpected_verdict: got status=%0d expected none", status_a);
                end else begin
                    e = q_a.pop_front();
                    check_verdict("A", e, status_a, fidx_a, fdata_a, matched_a, cnt_a);
                end
            end
            prev = done_a;
        end
    end

    initial begin : mon_b
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_b && !prev) begin
                if (q_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL B.unexpected_verdict: got status=%0d expected none", status_b);
                end else begin
                    e = q_b.pop_front();
                    check_verdict("B", e, status_b, fidx_b, fdata_b, matched_b, cnt_b);
                end
            end
            prev = done_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] v);
        chk_addr[i*XLEN +: XLEN]  = a;
        chk_value[i*XLEN +: XLEN] = v;
    endtask

    task automatic start_run(input logic [3:0] en);
        chk_en = en;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cur    = 0;
    endtask

    task automatic run_to(input int k);
        while (cur < k - 1) begin
            tick();
            cur++;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_en = 1'b1; mem_write_en = 1'b1; mem_adr = a; mem_write_data = d;
        tick();
        mem_en = 1'b0; mem_write_en = 1'b0;
        cur++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!(done_a && done_b) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (!(done_a && done_b)) begin
            bad++;
            $display("FAIL %s.wait_done: got done_a=%0b done_b=%0b expected both 1 within %0d cycles",
                     tag, done_a, done_b, budget);
        end
        @(negedge clk);
        #1;
    endtask

    function automatic exp_t mk(input status_t st, input logic [1:0] fi, input logic [31:0] fd,
                                input logic [3:0] m, input logic [31:0] c);
        exp_t e;
        e.st = st; e.fidx = fi; e.fdata = fd; e.matched = m; e.cnt = c;
        return e;
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; mem_en = 1'b0; mem_write_en = 1'b0; instr_valid = 1'b1;
        chk_en = '0; chk_addr = '0; chk_value = '0; mem_adr = '0; mem_write_data = '0;
        repeat (3) tick();
        check_now("reset", 1'b0, ST_IDLE, 4'b0000, 32'd0);
        reset = 1'b1;
        bus_write(32'hC, 32'hF);
        tick();
        check_now("idle", 1'b0, ST_IDLE, 4'b0000, 32'd0);

        // Single slot, correct value on cycle 40
        set_slot(0, 32'hC, 32'h0F); set_slot(1, 32'h80, 32'h1);
        set_slot(2, 32'h84, 32'h2); set_slot(3, 32'h88, 32'h3);
        q_a.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0001, 32'd40));
        q_b.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0001, 32'd40));
        start_run(4'b0001);
        run_to(40); bus_write(32'hC, 32'h0F);
        wait_done("t1", 10);

        // Wrong value on cycle 5, started from PASS
        q_a.push_back(mk(ST_FAIL_VALUE, 2'd0, 32'h0E, 4'b0000, 32'd5));
        q_b.push_back(mk(ST_FAIL_VALUE, 2'd0, 32'h0E, 4'b0000, 32'd5));
        start_run(4'b0001);
        run_to(5); bus_write(32'hC, 32'h0E);
        wait_done("t2", 10);

        // Out-of-order completion: ordered instance rejects, unordered passes
        set_slot(0, 32'h10, 32'h1); set_slot(1, 32'h14, 32'h2);
        q_a.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0011, 32'd4));
        q_b.push_back(mk(ST_FAIL_ORDER, 2'd1, 32'h2, 4'b0000, 32'd3));
        start_run(4'b0011);
        run_to(3); bus_write(32'h14, 32'h2); bus_write(32'h10, 32'h1);
        wait_done("t3", 10);

        // No writes: timeout after exactly TO RUN cycles
        q_a.push_back(mk(ST_TIMEOUT, 2'd0, 32'h0, 4'b0000, 32'd50));
        q_b.push_back(mk(ST_TIMEOUT, 2'd0, 32'h0, 4'b0000, 32'd50));
        start_run(4'b0001);
        wait_done("t4a", 80);

        // Ignored writes (disabled slot, already matched slot), then last match on cycle 50
        // coinciding with a bad fetch: completion wins
        set_slot(2, 32'h99, 32'h7);
        q_a.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0011, 32'd50));
        q_b.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0011, 32'd50));
        start_run(4'b0011);
        run_to(5);  bus_write(32'h99, 32'h5);
        run_to(10); bus_write(32'h10, 32'h1);
        run_to(20); bus_write(32'h10, 32'h5);
        run_to(50); instr_valid = 1'b0; bus_write(32'h14, 32'h2); instr_valid = 1'b1;
        wait_done("t4b", 10);

        // Fetch past the program on cycle 20
        q_a.push_back(mk(ST_FAIL_FETCH, 2'd0, 32'h0, 4'b0000, 32'd20));
        q_b.push_back(mk(ST_FAIL_FETCH, 2'd0, 32'h0, 4'b0000, 32'd20));
        start_run(4'b0001);
        run_to(20); instr_valid = 1'b0; tick(); instr_valid = 1'b1; cur++;
        wait_done("t5a", 10);

        // Asynchronous reset mid-run discards everything
        start_run(4'b0001);
        run_to(10);
        #2 reset = 1'b0;
        #1 check_now("midreset", 1'b0, ST_IDLE, 4'b0000, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_now("postreset", 1'b0, ST_IDLE, 4'b0000, 32'd0);

        // Nothing enabled: PASS on the first RUN cycle
        q_a.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0000, 32'd1));
        q_b.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0000, 32'd1));
        start_run(4'b0000);
        tick();
        check_now("noen", 1'b1, ST_PASS, 4'b0000, 32'd1);
        @(negedge clk); #1;

        // Restart from PASS clears matched
        set_slot(0, 32'hC, 32'h0F);
        q_a.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0001, 32'd2));
        q_b.push_back(mk(ST_PASS, 2'd0, 32'h0, 4'b0001, 32'd2));
        start_run(4'b0001);
        run_to(2); bus_write(32'hC, 32'h0F);
        wait_done("t6", 10);
        start_run(4'b0001);
        check_now("restart", 1'b0, ST_RUN, 4'b0000, 32'd0);

        repeat (2) tick();
        chk32("A.queue_left", 32'(q_a.size()), 32'd0);
        chk32("B.queue_left", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
